pipelined_selector: RTL

PIPELINED_SELECTOR -- requirements
Module: pipelined_selector

---
 rtl/pipelined_selector.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipelined_selector.sv
// Pipelined channel selector: picks values[index] on acceptance and presents it
// LATENCY cycles later through a valid/ready handshake with a stall-all pipeline.
module pipelined_selector #(
    parameter int CHANNELS = 7,
    parameter int WIDTH    = 32,
    parameter int LATENCY  = 1,
    localparam int IW      = $clog2(CHANNELS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    index,
    input  logic [WIDTH-1:0] values [CHANNELS],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outcome,
    output logic [IW-1:0]    out_index,
    output logic             out_error,
    output logic             err_sticky,
    input  logic             err_clear,
    output logic [15:0]      sel_count
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic out_of_range(input logic [IW-1:0] idx);
        return int'(idx) >= CHANNELS;
    endfunction

    logic                 stall;
    logic                 accept;
    logic                 oor;
    logic [WIDTH-1:0]     sel_value;

    logic [LATENCY-1:0]   vld_q, vld_d;
    logic [WIDTH-1:0]     data_q [LATENCY];
    logic [WIDTH-1:0]     data_d [LATENCY];
    logic [IW-1:0]        idx_q  [LATENCY];
    logic [IW-1:0]        idx_d  [LATENCY];
    logic [LATENCY-1:0]   err_q, err_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [15:0]          cnt_q, cnt_d;

    always_comb begin
        stall  = vld_q[LATENCY-1] & ~out_ready;
        accept = in_valid & ~stall;
        oor    = out_of_range(index);

        // Out-of-range indices match no channel and therefore select zero.
        sel_value = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (index == IW'(c)) begin
                sel_value = values[c];
            end
        end

        vld_d  = vld_q;
        data_d = data_q;
        idx_d  = idx_q;
        err_d  = err_q;

        // Payload only moves behind a valid bit so idle outputs keep their last value.
        if (!stall) begin
            for (int i = LATENCY - 1; i >= 1; i--) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                    idx_d[i]  = idx_q[i-1];
                    err_d[i]  = err_q[i-1];
                end
            end
            vld_d[0] = accept;
            if (accept) begin
                data_d[0] = sel_value;
                idx_d[0]  = index;
                err_d[0]  = oor;
            end
        end

        err_sticky_d = err_sticky_q;
        if (err_clear) begin
            err_sticky_d = 1'b0;
        end
        if (accept && oor) begin
            err_sticky_d = 1'b1;
        end

        cnt_d = cnt_q;
        if (vld_q[LATENCY-1] && out_ready) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Stage registers; the last stage drives the outputs directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q        <= '0;
            err_q        <= '0;
            err_sticky_q <= 1'b0;
            cnt_q        <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
                idx_q[i]  <= '0;
            end
        end else begin
            vld_q        <= vld_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
                idx_q[i]  <= idx_d[i];
            end
        end
    end

    assign in_ready   = ~stall;
    assign out_valid  = vld_q[LATENCY-1];
    assign outcome    = data_q[LATENCY-1];
    assign out_index  = idx_q[LATENCY-1];
    assign out_error  = err_q[LATENCY-1];
    assign err_sticky = err_sticky_q;
    assign sel_count  = cnt_q;

endmodule
